partition_link_arbiter: RTL and testbench
=========================================

# partition_link_arbiter

Parametrised successor to the single-link final arbitration stage of a split decoder partition. It merges `CHANNEL_COUNT` master-FIFO channels onto `LINK_COUNT` inter-partition links, with round-robin arbitration and a tag-based return path. The stage-controller channel is treated as the highest-index channel. It sits between one partition's grid/stage controller and the physical links to neighbouring partitions. It also reports in-flight traffic to that partition's stage controller.

## Interface
- `CHANNEL_COUNT`, 21: channels, including the stage-controller channel at index `CHANNEL_COUNT-1`.
- `MSG_WIDTH`, 20: payload width, i.e. union message + 2 flag bits.
- `LINK_COUNT`, 2: physical links.
- `FIFO_DEPTH`, 4: entries per link FIFO, in each direction; power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `ch_out_data` in `MSG_WIDTH*CHANNEL_COUNT`: outbound payloads, packed with channel c at bits `[c*MSG_WIDTH +: MSG_WIDTH]`.
- `ch_out_valid` in `CHANNEL_COUNT`, `ch_out_ready` out `CHANNEL_COUNT`: outbound handshake.
- `ch_in_data` out `MSG_WIDTH*CHANNEL_COUNT`: inbound payloads, same packing as `ch_out_data`.
- `ch_in_valid` out `CHANNEL_COUNT`, `ch_in_ready` in `CHANNEL_COUNT`: inbound handshake.
- `link_out_data` out `LINK_W*LINK_COUNT`, where `LINK_W = MSG_WIDTH + TAG_W` and `TAG_W = $clog2(CHANNEL_COUNT)`; word = {tag, payload}.
- `link_out_valid` out `LINK_COUNT`, `link_out_ready` in `LINK_COUNT`.
- `link_in_data` in `LINK_W*LINK_COUNT`, `link_in_valid` in `LINK_COUNT`, `link_in_ready` out `LINK_COUNT`.
- `has_flying_messages` out 1: registered OR of all link FIFOs being non-empty.
- `tag_error` out 1: one-cycle pulse when an inbound word is dropped.

## Operation
- Static mapping: channel c is served by link `c % LINK_COUNT`.
- **Outbound, per link:**
  - Round-robin arbiter over the channels mapped to that link.
  - Search starts at the pointer and wraps.
  - Grant only when the link's TX FIFO is not full.
  - `ch_out_ready[c]` = grant[c], combinational; at most one grant per link per cycle.
  - A granted word is pushed as {c, payload}.
  - On a grant the pointer moves to the granted channel + 1, with wrap; otherwise it holds.
- **TX FIFO:** `link_out_valid` = not empty; data = head; pop on valid&ready.
- **Inbound, per link:**
  - RX FIFO with `link_in_ready` = not full.
  - Head tag t selects the destination; `ch_in_valid[t]` and `ch_in_data[t]` come from that head.
  - Pop on `ch_in_valid[t]` & `ch_in_ready[t]`.
- **Collisions:** if several RX heads target the same channel, the lowest link index wins; the others hold.
- **Bad tag:** a head with t ≥ `CHANNEL_COUNT` is popped unconditionally and pulses `tag_error` the next cycle.
- **Empty/full:** push and pop on the same cycle are allowed unless the FIFO is full, because ready = !full and there is no bypass. The count stays unchanged on a simultaneous push+pop.
- **Reset state:** all FIFOs empty, pointers 0. All outputs 0, including every `*_ready`, `*_valid`, `has_flying_messages` and `tag_error`.
- **Reset mid-operation:** all in-flight words are discarded and nothing is replayed.

## Timing
- Outbound: `ch_out` handshake in cycle N → `link_out_valid` in N+1.
- Inbound: `link_in` handshake in N → `ch_in_valid` in N+1.
- `has_flying_messages` lags FIFO occupancy by one cycle.
- With all FIFOs idle: asserts at N+2 after a push in N, and deasserts one cycle after the last pop empties the last FIFO.
- Sustained throughput: one word per link per cycle in each direction.
- `ch_in_data` is don't-care when `ch_in_valid` is low; drive it to 0.

## Configuration
- `PARTITION_LINK_STATS_EN`
  - Defined: adds output `link_stats` of width `32*LINK_COUNT`. Per link it holds 16-bit saturating counts {TX words popped, RX words dropped for bad tag}. Counters clear on reset and saturate at 16'hFFFF.
  - Undefined: no port and no counters; behaviour is otherwise identical.

## Structure
- Package `partition_link_pkg`:
  - `TAG_W`/`LINK_W` helper functions.
  - Typedef for the link word struct {tag, payload}.
  - `LINK_OF(c)` mapping function.
- Sub-module `partition_link_fifo`: synchronous FIFO, depth `FIFO_DEPTH`, registered head, async active-low reset. It is instantiated 2×`LINK_COUNT` times.
- Arbiters and the RX router are in the top module.

## Test plan
- **Single word:** `ch_out_valid[3]`, payload 20'hABCDE, default parameters → `link_out_valid[1]` one cycle later with data {5'd3, 20'hABCDE}.
- **Fairness:** channels 0, 2, 4 all valid continuously with `link_out_ready[0]`=1 → grant order 0, 2, 4, 0, 2, 4…; no channel starves.
- **Backpressure:** `link_out_ready[0]`=0 for 10 cycles with channel 0 valid → exactly 4 words accepted, then `ch_out_ready[0]`=0. Releasing ready drains them in order.
- **Collision:** both RX heads tagged 7 and `ch_in_ready[7]`=1 → link 0's word is delivered first and link 1's on the next cycle.
- **Bad tag and flying flag:** a link-in word with tag 5'd25 → dropped, `tag_error` pulse, `has_flying_messages` returns to 0. Also assert reset mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/partition_link_pkg.sv
// rtl/partition_link_pkg.sv - shared widths, link word layout and channel-to-link mapping
//
// Purpose : helpers shared by the partition link arbiter and its bench.
// Contents: tag_w_of / link_w_of width helpers, link_word_t {tag, payload}
//           for the default geometry, LINK_OF channel-to-link mapping.
package partition_link_pkg;

  localparam int DEF_CHANNEL_COUNT = 21;
  localparam int DEF_MSG_WIDTH     = 20;

  // Tag wide enough to name every channel; a single channel still gets one bit.
  function automatic int tag_w_of(input int channel_count);
    return (channel_count > 1) ? $clog2(channel_count) : 1;
  endfunction

  function automatic int link_w_of(input int msg_width, input int channel_count);
    return msg_width + tag_w_of(channel_count);
  endfunction

  localparam int DEF_TAG_W = tag_w_of(DEF_CHANNEL_COUNT);

  typedef struct packed {
    logic [DEF_TAG_W-1:0]     tag;
    logic [DEF_MSG_WIDTH-1:0] payload;
  } link_word_t;

  // Static striping of channels over links.
  function automatic int LINK_OF(input int channel, input int link_count);
    return channel % link_count;
  endfunction

endpackage

// File: rtl/partition_link_fifo.sv
// rtl/partition_link_fifo.sv - synchronous FIFO with registered storage for one link direction
//
// Purpose : per-link buffering for the partition link arbiter (TX and RX).
// Ports   : clk, reset (async active-low)
//           push, push_data  - write side; ignored when full
//           pop, pop_data    - read side; pop_data is the current head, 0 when empty
//           empty, full      - occupancy flags
module partition_link_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Stale entries are hidden so an idle link presents all-zero data.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/partition_link_arbiter.sv
// rtl/partition_link_arbiter.sv - merges partition channels onto inter-partition links with tag return path
//
// Purpose : round-robin merge of CHANNEL_COUNT channels onto LINK_COUNT links
//           (channel c -> link c % LINK_COUNT), tagged words out, tag-routed
//           words back in. Channel CHANNEL_COUNT-1 is the stage controller.
// Ports   : clk, reset (async active-low)
//           ch_out_data/valid/ready   - outbound channel handshake
//           ch_in_data/valid/ready    - inbound channel handshake
//           link_out_data/valid/ready - outbound link words {tag, payload}
//           link_in_data/valid/ready  - inbound link words {tag, payload}
//           has_flying_messages       - registered "any link FIFO non-empty"
//           tag_error                 - one-cycle pulse per cycle with a dropped inbound word
//           link_stats                - only with PARTITION_LINK_STATS_EN: per link
//                                       {TX words popped, RX bad-tag drops}, 16-bit saturating
module partition_link_arbiter
  import partition_link_pkg::*;
#(
  parameter int CHANNEL_COUNT = 21,
  parameter int MSG_WIDTH     = 20,
  parameter int LINK_COUNT    = 2,
  parameter int FIFO_DEPTH    = 4,
  localparam int TAG_W        = tag_w_of(CHANNEL_COUNT),
  localparam int LINK_W       = link_w_of(MSG_WIDTH, CHANNEL_COUNT)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MSG_WIDTH*CHANNEL_COUNT-1:0] ch_out_data,
  input  logic [CHANNEL_COUNT-1:0]           ch_out_valid,
  output logic [CHANNEL_COUNT-1:0]           ch_out_ready,
  output logic [MSG_WIDTH*CHANNEL_COUNT-1:0] ch_in_data,
  output logic [CHANNEL_COUNT-1:0]           ch_in_valid,
  input  logic [CHANNEL_COUNT-1:0]           ch_in_ready,
  output logic [LINK_W*LINK_COUNT-1:0]       link_out_data,
  output logic [LINK_COUNT-1:0]              link_out_valid,
  input  logic [LINK_COUNT-1:0]              link_out_ready,
  input  logic [LINK_W*LINK_COUNT-1:0]       link_in_data,
  input  logic [LINK_COUNT-1:0]              link_in_valid,
  output logic [LINK_COUNT-1:0]              link_in_ready,
  output logic                               has_flying_messages,
  output logic                               tag_error
`ifdef PARTITION_LINK_STATS_EN
  ,
  output logic [32*LINK_COUNT-1:0]           link_stats
`endif
);

  logic [TAG_W-1:0]  ptr_q        [LINK_COUNT];
  logic [TAG_W-1:0]  ptr_d        [LINK_COUNT];
  logic [LINK_W-1:0] tx_push_data [LINK_COUNT];
  logic [LINK_W-1:0] tx_head      [LINK_COUNT];
  logic [LINK_W-1:0] rx_head      [LINK_COUNT];
  logic [LINK_COUNT-1:0] tx_push, tx_pop, tx_empty, tx_full;
  logic [LINK_COUNT-1:0] rx_push, rx_pop, rx_empty, rx_full;
  logic [LINK_COUNT-1:0] bad;

  // Outbound arbitration: per link, scan channels starting at the pointer and
  // wrapping; the first valid channel mapped to this link wins. reset gates the
  // grant so every ready output is low while reset is held.
  always_comb begin : arb
    logic found;
    int   idx;
    ch_out_ready = '0;
    for (int l = 0; l < LINK_COUNT; l++) begin
      found           = 1'b0;
      ptr_d[l]        = ptr_q[l];
      tx_push[l]      = 1'b0;
      tx_push_data[l] = '0;
      for (int o = 0; o < CHANNEL_COUNT; o++) begin
        idx = int'(ptr_q[l]) + o;
        if (idx >= CHANNEL_COUNT) idx = idx - CHANNEL_COUNT;
        if (!found && reset && !tx_full[l] && (LINK_OF(idx, LINK_COUNT) == l) && ch_out_valid[idx]) begin
          found             = 1'b1;
          ch_out_ready[idx] = 1'b1;
          tx_push[l]        = 1'b1;
          tx_push_data[l]   = {TAG_W'(idx), ch_out_data[idx*MSG_WIDTH +: MSG_WIDTH]};
          ptr_d[l]          = (idx == CHANNEL_COUNT-1) ? '0 : TAG_W'(idx + 1);
        end
      end
    end
  end

  // Inbound routing: links are visited in ascending order so the lowest link
  // claims a contested channel; losers keep their head for a later cycle.
  // Heads with an out-of-range tag are discarded without waiting for anyone.
  always_comb begin : route
    logic [CHANNEL_COUNT-1:0] claimed;
    int t;
    claimed     = '0;
    ch_in_valid = '0;
    ch_in_data  = '0;
    rx_pop      = '0;
    bad         = '0;
    for (int l = 0; l < LINK_COUNT; l++) begin
      t = int'(rx_head[l][LINK_W-1 -: TAG_W]);
      if (!rx_empty[l]) begin
        if (t >= CHANNEL_COUNT) begin
          rx_pop[l] = 1'b1;
          bad[l]    = 1'b1;
        end else if (!claimed[t]) begin
          claimed[t]                           = 1'b1;
          ch_in_valid[t]                       = 1'b1;
          ch_in_data[t*MSG_WIDTH +: MSG_WIDTH] = rx_head[l][MSG_WIDTH-1:0];
          rx_pop[l]                            = ch_in_ready[t];
        end
      end
    end
  end

  for (genvar l = 0; l < LINK_COUNT; l++) begin : g_link
    assign tx_pop[l]                           = !tx_empty[l] && link_out_ready[l];
    assign link_out_valid[l]                   = !tx_empty[l];
    assign link_out_data[l*LINK_W +: LINK_W]   = tx_head[l];
    assign link_in_ready[l]                    = reset && !rx_full[l];
    assign rx_push[l]                          = link_in_valid[l] && link_in_ready[l];

    partition_link_fifo #(.WIDTH(LINK_W), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push[l]),
      .push_data (tx_push_data[l]),
      .pop       (tx_pop[l]),
      .pop_data  (tx_head[l]),
      .empty     (tx_empty[l]),
      .full      (tx_full[l])
    );

    partition_link_fifo #(.WIDTH(LINK_W), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push[l]),
      .push_data (link_in_data[l*LINK_W +: LINK_W]),
      .pop       (rx_pop[l]),
      .pop_data  (rx_head[l]),
      .empty     (rx_empty[l]),
      .full      (rx_full[l])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < LINK_COUNT; l++) ptr_q[l] <= '0;
      tag_error           <= 1'b0;
      has_flying_messages <= 1'b0;
    end else begin
      for (int l = 0; l < LINK_COUNT; l++) ptr_q[l] <= ptr_d[l];
      tag_error           <= |bad;
      has_flying_messages <= !(&tx_empty) || !(&rx_empty);
    end
  end

`ifdef PARTITION_LINK_STATS_EN
  logic [15:0] tx_cnt_q   [LINK_COUNT];
  logic [15:0] drop_cnt_q [LINK_COUNT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < LINK_COUNT; l++) begin
        tx_cnt_q[l]   <= '0;
        drop_cnt_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LINK_COUNT; l++) begin
        if (tx_pop[l] && (tx_cnt_q[l] != 16'hFFFF)) tx_cnt_q[l] <= tx_cnt_q[l] + 16'd1;
        if (bad[l] && (drop_cnt_q[l] != 16'hFFFF)) drop_cnt_q[l] <= drop_cnt_q[l] + 16'd1;
      end
    end
  end

  for (genvar l = 0; l < LINK_COUNT; l++) begin : g_stats
    assign link_stats[l*32 +: 32] = {tx_cnt_q[l], drop_cnt_q[l]};
  end
`endif

endmodule

// File: tb/tb_partition_link_arbiter.sv
// tb/tb_partition_link_arbiter.sv - directed self-checking bench for partition_link_arbiter
module tb_partition_link_arbiter;
  import partition_link_pkg::*;

  localparam int CC = 21;
  localparam int MW = 20;
  localparam int LC = 2;
  localparam int TW = 5;
  localparam int LW = 25;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [MW*CC-1:0]  ch_out_data = '0;
  logic [CC-1:0]     ch_out_valid = '0;
  logic [CC-1:0]     ch_out_ready;
  logic [MW*CC-1:0]  ch_in_data;
  logic [CC-1:0]     ch_in_valid;
  logic [CC-1:0]     ch_in_ready = '0;
  logic [LW*LC-1:0]  link_out_data;
  logic [LC-1:0]     link_out_valid;
  logic [LC-1:0]     link_out_ready = '0;
  logic [LW*LC-1:0]  link_in_data = '0;
  logic [LC-1:0]     link_in_valid = '0;
  logic [LC-1:0]     link_in_ready;
  logic              has_flying_messages;
  logic              tag_error;
`ifdef PARTITION_LINK_STATS_EN
  logic [32*LC-1:0]  link_stats;
`endif

  always #5 clk = ~clk;

  partition_link_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .ch_out_data         (ch_out_data),
    .ch_out_valid        (ch_out_valid),
    .ch_out_ready        (ch_out_ready),
    .ch_in_data          (ch_in_data),
    .ch_in_valid         (ch_in_valid),
    .ch_in_ready         (ch_in_ready),
    .link_out_data       (link_out_data),
    .link_out_valid      (link_out_valid),
    .link_out_ready      (link_out_ready),
    .link_in_data        (link_in_data),
    .link_in_valid       (link_in_valid),
    .link_in_ready       (link_in_ready),
    .has_flying_messages (has_flying_messages),
    .tag_error           (tag_error)
`ifdef PARTITION_LINK_STATS_EN
    ,
    .link_stats          (link_stats)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int         fair_seq [6] = '{0, 2, 4, 0, 2, 4};
  int         acc;
  link_word_t w;

  initial begin
    // Reset held with a channel requesting: nothing may be granted or valid.
    ch_out_valid = CC'(1) << 5;
    tick(); tick();
    #1;
    check_vec("rst_ch_out_ready", 64'(ch_out_ready), 64'h0);
    check_vec("rst_link_out_valid", 64'(link_out_valid), 64'h0);
    check_vec("rst_link_in_ready", 64'(link_in_ready), 64'h0);
    check_vec("rst_ch_in_valid", 64'(ch_in_valid), 64'h0);
    check_vec("rst_flying", 64'(has_flying_messages), 64'h0);
    check_vec("rst_tag_error", 64'(tag_error), 64'h0);
    check_vec("rst_link_out_data", 64'(link_out_data), 64'h0);
    reset = 1'b1;
    ch_out_valid = '0;
    tick();
    #1;
    check_vec("post_rst_link_in_ready", 64'(link_in_ready), 64'h3);

    // Single word on channel 3 -> link 1, tagged 3, one cycle later.
    tick();
    ch_out_valid = CC'(1) << 3;
    ch_out_data[3*MW +: MW] = 20'hABCDE;
    #1;
    check_vec("single_grant", 64'(ch_out_ready), 64'h8);
    tick();
    ch_out_valid = '0;
    #1;
    check_vec("single_valid", 64'(link_out_valid), 64'h2);
    check_vec("single_data", 64'(link_out_data[LW +: LW]), 64'h03ABCDE);
    check_vec("single_flying_lag", 64'(has_flying_messages), 64'h0);
    link_out_ready = 2'b10;
    tick();
    #1;
    check_vec("single_drained", 64'(link_out_valid), 64'h0);
    check_vec("single_flying_on", 64'(has_flying_messages), 64'h1);
    tick();
    #1;
    check_vec("single_flying_off", 64'(has_flying_messages), 64'h0);

    // Fairness: channels 0, 2, 4 share link 0 and rotate.
    tick();
    link_out_ready = 2'b11;
    ch_out_valid = CC'(21'b10101);
    ch_out_data[0*MW +: MW] = 20'h00011;
    ch_out_data[2*MW +: MW] = 20'h00022;
    ch_out_data[4*MW +: MW] = 20'h00044;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_vec("fair_grant", 64'(ch_out_ready), 64'(1) << fair_seq[i]);
      if (i > 0) check_vec("fair_tag", 64'(link_out_data[LW-1 -: TW]), 64'(fair_seq[i-1]));
      tick();
    end
    ch_out_valid = '0;
    tick();

    // Backpressure: link 0 stalled, channel 0 keeps offering.
    link_out_ready[0] = 1'b0;
    ch_out_valid = CC'(1);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      ch_out_data[0 +: MW] = MW'(20'h00100 + i);
      #1;
      if (ch_out_ready[0]) acc++;
      tick();
    end
    #1;
    check_vec("bp_accepted", 64'(acc), 64'd4);
    check_vec("bp_ready_low", 64'(ch_out_ready[0]), 64'h0);
    check_vec("bp_valid", 64'(link_out_valid[0]), 64'h1);
    ch_out_valid = '0;
    link_out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec("bp_drain", 64'(link_out_data[0 +: LW]), 64'h100 + 64'(k));
      tick();
    end
    #1;
    check_vec("bp_empty", 64'(link_out_valid[0]), 64'h0);
    tick();
    tick();

    // Collision: both links deliver to channel 7; link 0 goes first.
    ch_in_ready = '0;
    w.tag = 5'd7; w.payload = 20'h77770; link_in_data[0 +: LW] = w;
    w.tag = 5'd7; w.payload = 20'h77771; link_in_data[LW +: LW] = w;
    link_in_valid = 2'b11;
    tick();
    link_in_valid = '0;
    #1;
    check_vec("coll_valid0", 64'(ch_in_valid), 64'(1) << 7);
    check_vec("coll_data0", 64'(ch_in_data[7*MW +: MW]), 64'h77770);
    ch_in_ready[7] = 1'b1;
    tick();
    #1;
    check_vec("coll_valid1", 64'(ch_in_valid), 64'(1) << 7);
    check_vec("coll_data1", 64'(ch_in_data[7*MW +: MW]), 64'h77771);
    tick();
    #1;
    check_vec("coll_done", 64'(ch_in_valid), 64'h0);
    tick();

    // Bad tag 25: dropped, tag_error pulse, flying flag returns to 0.
    w.tag = 5'd25; w.payload = 20'h12345; link_in_data[0 +: LW] = w;
    link_in_valid = 2'b01;
    tick();
    link_in_valid = '0;
    #1;
    check_vec("bad_no_deliver", 64'(ch_in_valid), 64'h0);
    check_vec("bad_err_pre", 64'(tag_error), 64'h0);
    check_vec("bad_flying_pre", 64'(has_flying_messages), 64'h0);
    tick();
    #1;
    check_vec("bad_err_pulse", 64'(tag_error), 64'h1);
    check_vec("bad_flying_on", 64'(has_flying_messages), 64'h1);
    tick();
    #1;
    check_vec("bad_err_clear", 64'(tag_error), 64'h0);
    check_vec("bad_flying_off", 64'(has_flying_messages), 64'h0);

    // Reset mid-burst: everything in flight is discarded at once.
    tick();
    link_out_ready = '0;
    ch_in_ready = '0;
    ch_out_valid = CC'(21'hF);
    w.tag = 5'd2; w.payload = 20'h0BEEF;
    link_in_data[0 +: LW] = w;
    link_in_data[LW +: LW] = w;
    link_in_valid = 2'b11;
    tick(); tick(); tick();
    #1;
    check_vec("burst_flying", 64'(has_flying_messages), 64'h1);
    check_vec("burst_valid", 64'(link_out_valid), 64'h3);
    reset = 1'b0;
    #1;
    check_vec("mid_rst_link_out_valid", 64'(link_out_valid), 64'h0);
    check_vec("mid_rst_link_out_data", 64'(link_out_data), 64'h0);
    check_vec("mid_rst_ch_out_ready", 64'(ch_out_ready), 64'h0);
    check_vec("mid_rst_link_in_ready", 64'(link_in_ready), 64'h0);
    check_vec("mid_rst_ch_in_valid", 64'(ch_in_valid), 64'h0);
    check_vec("mid_rst_flying", 64'(has_flying_messages), 64'h0);
    check_vec("mid_rst_tag_error", 64'(tag_error), 64'h0);
    tick();
    reset = 1'b1;
    ch_out_valid = '0;
    link_in_valid = '0;
    link_out_ready = 2'b11;
    tick();
    #1;
    check_vec("no_replay_out", 64'(link_out_valid), 64'h0);
    check_vec("no_replay_in", 64'(ch_in_valid), 64'h0);
    check_vec("no_replay_flying", 64'(has_flying_messages), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
